gt_4bit: RTL and testbench

- Registered unsigned magnitude comparator: asserts agtb when operand a is strictly greater than operand b.
- Leaf arithmetic block used wherever a clean, registered greater-than flag is needed (threshold checks, priority selection).
- Built from a cascade of per-bit compare cells, evaluated MSB-first, followed by one output register stage.

---
 rtl/gt_cmp_pkg.sv | 12 +
 rtl/gt_cell.sv | 18 +
 rtl/gt_4bit.sv | 72 +++++++
 tb/tb_gt_4bit.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/gt_cmp_pkg.sv
// Shared types and defaults for the registered magnitude comparator.
package gt_cmp_pkg;

  localparam int unsigned GT_DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    CMP_EQ,
    CMP_GT,
    CMP_LT
  } cmp_state_t;

endpackage

// File: rtl/gt_cell.sv
// One bit of the MSB-first compare cascade: forwards a decided result, resolves an undecided one.
module gt_cell
  import gt_cmp_pkg::*;
(
  input  logic       a_bit,
  input  logic       b_bit,
  input  cmp_state_t cmp_in,
  output cmp_state_t cmp_out
);

  always_comb begin
    cmp_out = cmp_in;
    if ((cmp_in == CMP_EQ) && (a_bit != b_bit)) begin
      cmp_out = a_bit ? CMP_GT : CMP_LT;
    end
  end

endmodule

// File: rtl/gt_4bit.sv
// Registered unsigned a > b comparator with one cycle latency.
// Defining GT_4BIT_FULL_CMP_EN adds registered aeqb and altb outputs.
module gt_4bit
  import gt_cmp_pkg::*;
#(
  parameter int unsigned WIDTH = GT_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic             agtb
`ifdef GT_4BIT_FULL_CMP_EN
  ,
  output logic             aeqb,
  output logic             altb
`endif
);

  // w_chain[WIDTH] seeds the MSB cell; w_chain[0] is the final verdict.
  cmp_state_t w_chain [WIDTH:0];

  assign w_chain[WIDTH] = CMP_EQ;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    gt_cell u_cell (
      .a_bit   (a[gi]),
      .b_bit   (b[gi]),
      .cmp_in  (w_chain[gi+1]),
      .cmp_out (w_chain[gi])
    );
  end

  logic r_valid;
  logic r_agtb;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_agtb  <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_agtb <= (w_chain[0] == CMP_GT);
      end
    end
  end

  assign out_valid = r_valid;
  assign agtb      = r_agtb;

`ifdef GT_4BIT_FULL_CMP_EN
  logic r_aeqb;
  logic r_altb;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_aeqb <= 1'b0;
      r_altb <= 1'b0;
    end else if (in_valid) begin
      r_aeqb <= (w_chain[0] == CMP_EQ);
      r_altb <= (w_chain[0] == CMP_LT);
    end
  end

  assign aeqb = r_aeqb;
  assign altb = r_altb;
`endif

endmodule

// File: tb/tb_gt_4bit.sv
// Randomized self-checking bench for gt_4bit against a plain-arithmetic reference model.
// Honours GT_4BIT_FULL_CMP_EN to also check aeqb/altb and their one-hot property.
module tb_gt_4bit;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [3:0] a;
  logic [3:0] b;
  logic       out_valid;
  logic       agtb;
`ifdef GT_4BIT_FULL_CMP_EN
  logic       aeqb;
  logic       altb;
`endif

  gt_4bit #(
    .WIDTH (4)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .agtb      (agtb)
`ifdef GT_4BIT_FULL_CMP_EN
    ,
    .aeqb      (aeqb),
    .altb      (altb)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference state: what the outputs must show after the most recent edge.
  logic m_valid = 1'b0;
  logic m_agtb  = 1'b0;
  logic m_aeqb  = 1'b0;
  logic m_altb  = 1'b0;

  task automatic check(input string tag, input logic obs, input logic exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0b expected %0b (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [3:0] av, input logic [3:0] bv);
    int ia;
    int ib;
    rst      = r;
    in_valid = v;
    a        = av;
    b        = bv;
    ia       = int'(av);
    ib       = int'(bv);
    @(posedge clk);
    if (r) begin
      m_valid = 1'b0;
      m_agtb  = 1'b0;
      m_aeqb  = 1'b0;
      m_altb  = 1'b0;
    end else if (v) begin
      m_valid = 1'b1;
      m_agtb  = (ia > ib);
      m_aeqb  = (ia == ib);
      m_altb  = (ia < ib);
    end else begin
      m_valid = 1'b0;
    end
    #1;
    check("out_valid", out_valid, m_valid);
    check("agtb", agtb, m_agtb);
`ifdef GT_4BIT_FULL_CMP_EN
    check("aeqb", aeqb, m_aeqb);
    check("altb", altb, m_altb);
    if (out_valid) check("onehot", agtb + aeqb + altb == 2'd1, 1'b1);
`endif
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    a        = 4'h0;
    b        = 4'h0;

    // Reset dominates a valid, greater input.
    step(1'b1, 1'b1, 4'hF, 4'h0);
    step(1'b1, 1'b1, 4'hF, 4'h0);
    check("reset_agtb", agtb, 1'b0);

    // Equal pairs.
    step(1'b0, 1'b1, 4'h0, 4'h0);
    step(1'b0, 1'b1, 4'hF, 4'hF);
    check("all_ones_eq", agtb, 1'b0);
    step(1'b0, 1'b1, 4'h1, 4'h1);

    // Greater pairs, including MSB-only decision and all-ones vs all-ones-1.
    step(1'b0, 1'b1, 4'h4, 4'h3);
    step(1'b0, 1'b1, 4'h5, 4'h4);
    step(1'b0, 1'b1, 4'h8, 4'h7);
    check("msb_only", agtb, 1'b1);
    step(1'b0, 1'b1, 4'hF, 4'hE);
    check("ones_vs_ones_m1", agtb, 1'b1);

    // Less pairs.
    step(1'b0, 1'b1, 4'h0, 4'h3);
    step(1'b0, 1'b1, 4'h2, 4'h3);
    step(1'b0, 1'b1, 4'h7, 4'h8);

    // Back-to-back stream then idle with hold.
    step(1'b0, 1'b1, 4'h4, 4'h3);
    step(1'b0, 1'b1, 4'h2, 4'h3);
    step(1'b0, 1'b1, 4'hF, 4'hF);
    step(1'b0, 1'b1, 4'h8, 4'h7);
    step(1'b0, 1'b0, 4'h0, 4'hF);
    check("idle_hold", agtb, 1'b1);
    step(1'b0, 1'b0, 4'h3, 4'h9);

    // Reset mid-stream.
    step(1'b0, 1'b1, 4'h4, 4'h3);
    step(1'b1, 1'b1, 4'h9, 4'h1);
    check("midreset_agtb", agtb, 1'b0);
    step(1'b0, 1'b0, 4'hF, 4'h0);

    // a = 0 never wins.
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 4'h0, 4'(i));

`ifdef GT_4BIT_FULL_CMP_EN
    for (int i = 0; i < 256; i++) step(1'b0, 1'b1, 4'(i >> 4), 4'(i));
`endif

    // Random traffic with sparse resets and idle cycles carrying junk operands.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 24) == 0, $urandom_range(0, 3) != 0,
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
